// File: rtl/hazard_sequencer.sv
// -----------------------------------------------------------------------------
// hazard_sequencer
//
// Pipeline hazard and stall sequencer for a five-stage in-order core.
// Decides, every cycle, which pipeline latches advance, which are flushed
// and whether the PC loads. It handles four conditions:
//   - data-memory wait
//   - taken-branch redirect
//   - load-use interlock
//   - instruction-fetch miss
// It also handles a sticky processor halt.
//
// Optional feature:
//   HAZARD_PERF_CNT_EN  when defined, builds saturating 16-bit stall/flush
//                       performance counters. When undefined, both counter
//                       outputs are tied to zero and no counter flops exist.
//
// Ports:
//   CLK                 rising-edge clock
//   nRST                asynchronous active-low reset
//   ihit                instruction fetch completes this cycle
//   dhit                data access in MEM completes this cycle
//   ifid_rs, ifid_rt    source registers of the instruction in ID
//   idex_dREN           instruction in EX is a load
//   idex_wsel           destination register of the instruction in EX
//   exmem_dREN/dWEN     memory read / write in MEM
//   exmem_branch_taken  redirect resolved in MEM
//   exmem_halt          halt instruction in MEM
//   pc_en               PC load enable
//   ifid_enable, ifid_flush, idex_enable, idex_flush, exmem_enable,
//   exmem_flush, memwb_enable
//                       pipeline latch controls
//   halt                processor halted (sticky until reset)
//   stall_cnt           cycles with pc_en=0 outside HALTED/reset (saturating)
//   flush_cnt           branch-flush cycles (saturating)
//   state_dbg           current sequencer state (0=RUN, 1=MEMWAIT, 2=HALTED)
//
// Handshake note: this block has no valid/ready channels. Every output is a
// level that applies to the current cycle and is consumed by the latches on
// the next rising edge of CLK.
// -----------------------------------------------------------------------------
module hazard_sequencer (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        ihit,
  input  logic        dhit,
  input  logic [4:0]  ifid_rs,
  input  logic [4:0]  ifid_rt,
  input  logic        idex_dREN,
  input  logic [4:0]  idex_wsel,
  input  logic        exmem_dREN,
  input  logic        exmem_dWEN,
  input  logic        exmem_branch_taken,
  input  logic        exmem_halt,
  output logic        pc_en,
  output logic        ifid_enable,
  output logic        ifid_flush,
  output logic        idex_enable,
  output logic        idex_flush,
  output logic        exmem_enable,
  output logic        exmem_flush,
  output logic        memwb_enable,
  output logic        halt,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt,
  output logic [1:0]  state_dbg
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_MEMWAIT = 2'd1,
    ST_HALTED  = 2'd2
  } state_t;

  state_t state;

  logic memop;
  logic freeze;
  logic load_use;

  assign memop  = exmem_dREN | exmem_dWEN;
  assign freeze = memop & ~dhit;

  // A load in EX whose destination feeds an operand of the instruction in ID.
  // Register 0 is hard-wired to zero, so it never creates a dependency.
  assign load_use = idex_dREN & (idex_wsel != 5'd0) &
                    ((idex_wsel == ifid_rs) | (idex_wsel == ifid_rt));

  // ---------------------------------------------------------------------------
  // State register.
  // A halt in MEM is latched only when MEM is not frozen. Then the halt
  // instruction itself retires through MEM/WB on the latching edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state <= ST_RUN;
    end else begin
      unique case (state)
        ST_RUN: begin
          if (exmem_halt && !freeze) state <= ST_HALTED;
          else if (freeze)           state <= ST_MEMWAIT;
        end
        ST_MEMWAIT: begin
          if (exmem_halt && !freeze) state <= ST_HALTED;
          else if (dhit)             state <= ST_RUN;
        end
        ST_HALTED: state <= ST_HALTED;
        default:   state <= ST_RUN;
      endcase
    end
  end

  assign state_dbg = state;

  // ---------------------------------------------------------------------------
  // Latch controls, highest priority first:
  // HALTED, freeze, branch, load-use, fetch miss, normal.
  // During reset, every control is forced low regardless of the inputs.
  // ---------------------------------------------------------------------------
  always_comb begin
    pc_en        = 1'b0;
    ifid_enable  = 1'b0;
    ifid_flush   = 1'b0;
    idex_enable  = 1'b0;
    idex_flush   = 1'b0;
    exmem_enable = 1'b0;
    exmem_flush  = 1'b0;
    memwb_enable = 1'b0;
    halt         = 1'b0;

    if (!nRST) begin
      // Everything stays low while reset is asserted.
    end else if (state == ST_HALTED) begin
      halt = 1'b1;
    end else if (freeze) begin
      // Whole pipe holds. A branch or halt sitting in MEM waits here for dhit.
    end else if (exmem_branch_taken) begin
      pc_en        = 1'b1;
      ifid_enable  = 1'b1;
      ifid_flush   = 1'b1;
      idex_enable  = 1'b1;
      idex_flush   = 1'b1;
      exmem_enable = 1'b1;
      exmem_flush  = 1'b1;
      memwb_enable = 1'b1;
    end else if (load_use || !ihit) begin
      // PC and IF/ID hold. ID/EX loads a bubble so the older instructions
      // drain one slot. This is the only case where a flush comes without
      // the matching enable being fully meaningful: idex is enabled here.
      idex_enable  = 1'b1;
      idex_flush   = 1'b1;
      exmem_enable = 1'b1;
      memwb_enable = 1'b1;
    end else begin
      pc_en        = 1'b1;
      ifid_enable  = 1'b1;
      idex_enable  = 1'b1;
      exmem_enable = 1'b1;
      memwb_enable = 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Performance counters
  // ---------------------------------------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
  logic stall_cycle;
  logic branch_flush;

  // pc_en is already low during reset; the HALTED check keeps halt time out
  // of the stall count.
  assign stall_cycle  = nRST & ~pc_en & (state != ST_HALTED);
  // A full flush triple only ever comes from the branch case.
  assign branch_flush = ifid_flush & exmem_flush;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt <= 16'd0;
      flush_cnt <= 16'd0;
    end else begin
      if (stall_cycle && (stall_cnt != 16'hFFFF))
        stall_cnt <= stall_cnt + 16'd1;
      if (branch_flush && (flush_cnt != 16'hFFFF))
        flush_cnt <= flush_cnt + 16'd1;
    end
  end
`else
  assign stall_cnt = 16'd0;
  assign flush_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_sequencer.sv
// -----------------------------------------------------------------------------
// tb_hazard_sequencer
//
// Self-checking bench for hazard_sequencer.
// - A directed vector table is applied in a loop.
// - Hand-written sequences cover halt, reset and counter saturation.
// - Randomized cycles are checked against a behavioural reference model.
// -----------------------------------------------------------------------------
module tb_hazard_sequencer;

  // Output vector bit order:
  // {pc_en, ifid_en, ifid_fl, idex_en, idex_fl, exmem_en, exmem_fl, memwb_en, halt}
  localparam logic [8:0] O_NORM = 9'b1_1_0_1_0_1_0_1_0;
  localparam logic [8:0] O_BUB  = 9'b0_0_0_1_1_1_0_1_0;
  localparam logic [8:0] O_BR   = 9'b1_1_1_1_1_1_1_1_0;
  localparam logic [8:0] O_FRZ  = 9'b0_0_0_0_0_0_0_0_0;
  localparam logic [8:0] O_HLT  = 9'b0_0_0_0_0_0_0_0_1;

  localparam int S_RUN  = 0;
  localparam int S_WAIT = 1;
  localparam int S_HALT = 2;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        ihit, dhit, idex_dREN, exmem_dREN, exmem_dWEN;
  logic        exmem_branch_taken, exmem_halt;
  logic [4:0]  ifid_rs, ifid_rt, idex_wsel;
  logic        pc_en, ifid_enable, ifid_flush, idex_enable, idex_flush;
  logic        exmem_enable, exmem_flush, memwb_enable, halt;
  logic [15:0] stall_cnt, flush_cnt;
  logic [1:0]  state_dbg;

  hazard_sequencer dut (
    .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
    .ifid_rs(ifid_rs), .ifid_rt(ifid_rt),
    .idex_dREN(idex_dREN), .idex_wsel(idex_wsel),
    .exmem_dREN(exmem_dREN), .exmem_dWEN(exmem_dWEN),
    .exmem_branch_taken(exmem_branch_taken), .exmem_halt(exmem_halt),
    .pc_en(pc_en), .ifid_enable(ifid_enable), .ifid_flush(ifid_flush),
    .idex_enable(idex_enable), .idex_flush(idex_flush),
    .exmem_enable(exmem_enable), .exmem_flush(exmem_flush),
    .memwb_enable(memwb_enable), .halt(halt),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .state_dbg(state_dbg)
  );

  // ---------------- clock ----------------
  always #5 CLK = ~CLK;

  // ---------------- vector record ----------------
  typedef struct {
    logic       ihit, dhit, ldr, dren, dwen, br, hlt;
    logic [4:0] rs, rt, wsel;
    logic [8:0] eo;
    int         est;
  } vec_t;

  vec_t tbl[$];

  int checks = 0;
  int errors = 0;

  // reference model state
  int          m_st;
  int unsigned m_stall, m_flush;

  function automatic vec_t mk(logic ih, logic dh, logic [4:0] rs, logic [4:0] rt,
                              logic ldr, logic [4:0] ws, logic dr, logic dw,
                              logic br, logic hl, logic [8:0] eo, int est);
    vec_t v;
    v.ihit = ih; v.dhit = dh; v.rs = rs; v.rt = rt; v.ldr = ldr; v.wsel = ws;
    v.dren = dr; v.dwen = dw; v.br = br; v.hlt = hl; v.eo = eo; v.est = est;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural rules: what the pipeline should do this cycle.
  function automatic logic [8:0] model_out(int st, vec_t v);
    bit memwait_now = (v.dren || v.dwen) && !v.dhit;
    bit dep = v.ldr && v.wsel != 0 && (v.wsel == v.rs || v.wsel == v.rt);
    if (st == S_HALT) return O_HLT;
    if (memwait_now)  return O_FRZ;
    if (v.br)         return O_BR;
    if (dep || !v.ihit) return O_BUB;
    return O_NORM;
  endfunction

  function automatic int model_next(int st, vec_t v);
    bit memwait_now = (v.dren || v.dwen) && !v.dhit;
    if (st == S_HALT) return S_HALT;
    if (v.hlt && !memwait_now) return S_HALT;
    if (st == S_RUN) return memwait_now ? S_WAIT : S_RUN;
    return v.dhit ? S_RUN : S_WAIT;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input vec_t v);
    ihit = v.ihit; dhit = v.dhit; ifid_rs = v.rs; ifid_rt = v.rt;
    idex_dREN = v.ldr; idex_wsel = v.wsel; exmem_dREN = v.dren;
    exmem_dWEN = v.dwen; exmem_branch_taken = v.br; exmem_halt = v.hlt;
  endtask

  function automatic logic [8:0] dut_out();
    return {pc_en, ifid_enable, ifid_flush, idex_enable, idex_flush,
            exmem_enable, exmem_flush, memwb_enable, halt};
  endfunction

  // Called on a negedge: drive, check, then advance one clock.
  task automatic step(input vec_t v, input bit use_tbl, input string tag);
    logic [8:0] eo;
    int nst;
    drive(v);
    #1;
    eo = model_out(m_st, v);
    chk({tag, " outputs"}, {23'd0, dut_out()}, {23'd0, eo});
    chk({tag, " state"}, {30'd0, state_dbg}, m_st);
    chk({tag, " stall_cnt"}, {16'd0, stall_cnt}, m_stall);
    chk({tag, " flush_cnt"}, {16'd0, flush_cnt}, m_flush);
    if (use_tbl) begin
      chk({tag, " tbl outputs"}, {23'd0, dut_out()}, {23'd0, v.eo});
      chk({tag, " tbl state"}, {30'd0, state_dbg}, v.est);
    end
    nst = model_next(m_st, v);
`ifdef HAZARD_PERF_CNT_EN
    if (eo[8] == 1'b0 && m_st != S_HALT && m_stall < 32'hFFFF) m_stall++;
    if (eo == O_BR && m_flush < 32'hFFFF) m_flush++;
`endif
    @(posedge CLK);
    m_st = nst;
    @(negedge CLK);
  endtask

  // Called on a negedge: pulse reset with provocative inputs, then release.
  task automatic do_reset(input string tag);
    vec_t v = mk(1, 1, 5'd1, 5'd2, 0, 5'd0, 0, 0, 1, 1, O_FRZ, S_RUN);
    nRST = 1'b0;
    drive(v);
    #1;
    chk({tag, " rst outputs"}, {23'd0, dut_out()}, 32'd0);
    chk({tag, " rst state"}, {30'd0, state_dbg}, S_RUN);
    chk({tag, " rst stall_cnt"}, {16'd0, stall_cnt}, 32'd0);
    chk({tag, " rst flush_cnt"}, {16'd0, flush_cnt}, 32'd0);
    m_st = S_RUN; m_stall = 0; m_flush = 0;
    @(negedge CLK);
    nRST = 1'b1;
  endtask

  // ---------------- main test ----------------
  initial begin
    vec_t v;
    int halted_cycles;
    nRST = 1'b0;
    m_st = S_RUN; m_stall = 0; m_flush = 0;
    drive(mk(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, O_NORM, S_RUN));
    @(negedge CLK);
    do_reset("init");

    // Directed vectors (rs, rt, wsel are 5-bit register numbers).
    //               ih dh rs rt ldr ws dr dw br hl  exp     state
    tbl.push_back(mk(1, 0, 1, 2, 0, 0, 0, 0, 0, 0, O_NORM, S_RUN));   // normal
    tbl.push_back(mk(1, 0, 5, 9, 1, 5, 0, 0, 0, 0, O_BUB,  S_RUN));   // load-use rs
    tbl.push_back(mk(1, 0, 5, 9, 0, 0, 0, 0, 0, 0, O_NORM, S_RUN));   // after bubble
    tbl.push_back(mk(1, 0, 3, 0, 1, 0, 0, 0, 0, 0, O_NORM, S_RUN));   // wsel=0 no stall
    tbl.push_back(mk(1, 0, 4, 7, 1, 7, 0, 0, 0, 0, O_BUB,  S_RUN));   // load-use rt
    tbl.push_back(mk(0, 0, 1, 2, 0, 0, 0, 0, 0, 0, O_BUB,  S_RUN));   // fetch miss
    tbl.push_back(mk(0, 0, 6, 2, 1, 6, 0, 0, 1, 0, O_BR,   S_RUN));   // branch beats lu
    tbl.push_back(mk(1, 0, 1, 2, 0, 0, 1, 0, 0, 0, O_FRZ,  S_RUN));   // dmiss 1
    tbl.push_back(mk(1, 0, 1, 2, 0, 0, 1, 0, 0, 0, O_FRZ,  S_WAIT));  // dmiss 2
    tbl.push_back(mk(1, 0, 1, 2, 0, 0, 1, 0, 0, 0, O_FRZ,  S_WAIT));  // dmiss 3
    tbl.push_back(mk(1, 1, 1, 2, 0, 0, 1, 0, 0, 0, O_NORM, S_WAIT));  // dhit
    tbl.push_back(mk(1, 0, 1, 2, 0, 0, 0, 0, 0, 0, O_NORM, S_RUN));   // back in RUN
    tbl.push_back(mk(1, 0, 1, 2, 0, 0, 0, 1, 1, 0, O_FRZ,  S_RUN));   // br held 1
    tbl.push_back(mk(1, 0, 1, 2, 0, 0, 0, 1, 1, 0, O_FRZ,  S_WAIT));  // br held 2
    tbl.push_back(mk(1, 1, 1, 2, 0, 0, 0, 1, 1, 0, O_BR,   S_WAIT));  // br on dhit
    tbl.push_back(mk(1, 0, 1, 2, 0, 0, 0, 0, 0, 0, O_NORM, S_RUN));
    tbl.push_back(mk(1, 0, 1, 2, 0, 0, 0, 1, 0, 1, O_FRZ,  S_RUN));   // halt held
    tbl.push_back(mk(1, 1, 1, 2, 0, 0, 0, 1, 0, 1, O_NORM, S_WAIT));  // halt latch
    tbl.push_back(mk(1, 0, 1, 2, 0, 0, 0, 0, 1, 0, O_HLT,  S_HALT));  // sticky
    tbl.push_back(mk(0, 0, 3, 3, 1, 3, 1, 0, 0, 0, O_HLT,  S_HALT));  // sticky

    for (int i = 0; i < tbl.size(); i++)
      step(tbl[i], 1'b1, $sformatf("vec%0d", i));

`ifdef HAZARD_PERF_CNT_EN
    chk("flush_cnt after branches", {16'd0, flush_cnt}, 32'd2);
`else
    chk("flush_cnt tied off", {16'd0, flush_cnt}, 32'd0);
`endif

    // Leave HALTED by reset.
    do_reset("halted");
    step(mk(1, 0, 1, 2, 0, 0, 0, 0, 0, 0, O_NORM, S_RUN), 1'b1, "post-halt");

    // Halt with no memory op: outputs normal on the latching edge, halted after.
    step(mk(1, 0, 1, 2, 0, 0, 0, 0, 0, 1, O_NORM, S_RUN), 1'b1, "halt-nomem");
    step(mk(1, 0, 1, 2, 0, 0, 0, 0, 0, 0, O_HLT, S_HALT), 1'b1, "halted");

    // Reset asserted mid-MEMWAIT leaves nothing pending.
    do_reset("pre-wait");
    step(mk(1, 0, 1, 2, 0, 0, 1, 0, 1, 0, O_FRZ, S_RUN), 1'b1, "wait-a");
    step(mk(1, 0, 1, 2, 0, 0, 1, 0, 1, 0, O_FRZ, S_WAIT), 1'b1, "wait-b");
    do_reset("mid-wait");
    step(mk(1, 0, 1, 2, 0, 0, 0, 0, 0, 0, O_NORM, S_RUN), 1'b1, "post-wait");

    // Long fetch stall for counter saturation.
    do_reset("pre-sat");
    drive(mk(0, 0, 1, 2, 0, 0, 0, 0, 0, 0, O_BUB, S_RUN));
    repeat (70000) @(negedge CLK);
`ifdef HAZARD_PERF_CNT_EN
    m_stall = 32'hFFFF;
`endif
    #1;
    chk("stall_cnt saturation", {16'd0, stall_cnt}, m_stall);
    chk("state during long stall", {30'd0, state_dbg}, S_RUN);
    @(negedge CLK);
    do_reset("post-sat");

    // Randomized cycles against the reference model.
    halted_cycles = 0;
    for (int n = 0; n < 1500; n++) begin
      v.ihit = ($urandom_range(0, 9) < 8);
      v.dhit = $urandom_range(0, 1);
      v.rs   = 5'($urandom_range(0, 7));
      v.rt   = 5'($urandom_range(0, 7));
      v.ldr  = ($urandom_range(0, 2) == 0);
      v.wsel = 5'($urandom_range(0, 7));
      v.dren = ($urandom_range(0, 4) == 0);
      v.dwen = ($urandom_range(0, 5) == 0);
      v.br   = ($urandom_range(0, 6) == 0);
      v.hlt  = ($urandom_range(0, 59) == 0);
      v.eo   = O_FRZ;
      v.est  = S_RUN;
      step(v, 1'b0, $sformatf("rand%0d", n));
      if (m_st == S_HALT) halted_cycles++;
      if (halted_cycles > 3) begin
        do_reset("rand");
        halted_cycles = 0;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
